// File: rtl/encoder_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the encoder arbiter.
// gnt is one-hot (encoder input format); gnt_id is its binary index (encoder output format).
interface encoder_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output req,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  req,
      output gnt, gnt_id, gnt_valid, timeout
   );
endinterface

// File: rtl/encoder_rr_arbiter.sv
// Round-robin arbiter for the shared 8-input encoder path, with an optional hold timeout.
// Every output is registered; a grant is always followed by at least one IDLE cycle.
module encoder_rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   encoder_rr_arbiter_if.slave bus
);
   localparam int HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [7:0]    gnt, gnt_nxt;
   logic [2:0]    gnt_id, gnt_id_nxt;
   logic          gnt_valid, gnt_valid_nxt;
   logic          timeout, timeout_nxt;
   logic [2:0]    ptr, ptr_nxt;
   logic [HW-1:0] hold, hold_nxt;

   logic [2:0]    sel;
   logic          others, rel_normal, rel_force;

   // Rotating scan: first set bit at ptr, ptr+1, ... wrapping modulo 8.
   always_comb begin
      logic [2:0] idx;
      logic       found;
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = ptr + 3'(k);
         if (!found && bus.req[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   // Normal release wins over a forced one, so timeout only flags a real revocation.
   assign others     = |(bus.req & ~gnt);
   assign rel_normal = !bus.req[gnt_id];
   assign rel_force  = (MAX_HOLD != 0) && (hold == HW'(HOLD_LAST)) && others && !rel_normal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         ptr       <= '0;
         hold      <= '0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         gnt_id    <= gnt_id_nxt;
         gnt_valid <= gnt_valid_nxt;
         timeout   <= timeout_nxt;
         ptr       <= ptr_nxt;
         hold      <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|bus.req) state_nxt = GRANT;
         GRANT:   if (rel_normal || rel_force) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt       = gnt;
      gnt_id_nxt    = gnt_id;
      gnt_valid_nxt = gnt_valid;
      timeout_nxt   = 1'b0;
      ptr_nxt       = ptr;
      hold_nxt      = hold;
      case (state)
         IDLE: begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            if (|bus.req) begin
               gnt_nxt       = 8'(1) << sel;
               gnt_id_nxt    = sel;
               gnt_valid_nxt = 1'b1;
               hold_nxt      = '0;
            end
         end
         GRANT: begin
            if (rel_normal || rel_force) begin
               gnt_nxt       = '0;
               gnt_valid_nxt = 1'b0;
               ptr_nxt       = gnt_id + 3'd1;
               timeout_nxt   = rel_force;
            end else if (hold != HW'(HOLD_LAST)) begin
               hold_nxt = hold + HW'(1);
            end
         end
         default: begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
         end
      endcase
   end

   assign bus.gnt       = gnt;
   assign bus.gnt_id    = gnt_id;
   assign bus.gnt_valid = gnt_valid;
   assign bus.timeout   = timeout;
endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Directed bench for encoder_rr_arbiter (MAX_HOLD=4): rotation, pointer priority,
// timeout, lone holder and asynchronous reset, each against hand-computed values.
module tb_encoder_rr_arbiter;
   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   encoder_rr_arbiter_if bus ();

   encoder_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] id);
      chk({tag, ".valid"},   {7'd0, bus.gnt_valid}, 8'd1);
      chk({tag, ".gnt"},     bus.gnt,               8'(1) << id);
      chk({tag, ".gnt_id"},  {5'd0, bus.gnt_id},    {5'd0, id});
      chk({tag, ".timeout"}, {7'd0, bus.timeout},   8'd0);
   endtask

   task automatic chk_idle(input string tag, input logic to);
      chk({tag, ".valid"},   {7'd0, bus.gnt_valid}, 8'd0);
      chk({tag, ".gnt"},     bus.gnt,               8'd0);
      chk({tag, ".timeout"}, {7'd0, bus.timeout},   {7'd0, to});
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.req = 8'h00;
      step();
      step();
      chk_idle("reset", 1'b0);
      chk("reset.gnt_id", {5'd0, bus.gnt_id}, 8'd0);
      rst_n = 1'b1;
      step();
      chk_idle("idle_no_req", 1'b0);

      // Rotation from ptr=0: each grantee drops req for one cycle.
      for (int k = 0; k < 9; k++) begin
         bus.req = 8'hFF;
         step();
         chk_grant($sformatf("rot%0d", k), 3'(k % 8));
         bus.req = 8'hFF & ~(8'(1) << (k % 8));
         step();
         chk_idle($sformatf("rot%0d.gap", k), 1'b0);
      end

      // Single request held 5 cycles (ptr=1 here, scan reaches 2).
      bus.req = 8'b0000_0100;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_grant($sformatf("single.c%0d", k), 3'd2);
      end
      bus.req = 8'h00;
      step();
      chk_idle("single.rel", 1'b0);
      chk("single.id_hold", {5'd0, bus.gnt_id}, 8'd2);
      // ptr=3 means bit 3 beats bit 0.
      bus.req = 8'b0000_1001;
      step();
      chk_grant("single.ptr3", 3'd3);

      // Pointer priority: requester 5 grant/release leaves ptr=6.
      bus.req = 8'h00;
      step();
      bus.req = 8'b0010_0000;
      step();
      chk_grant("prio.g5", 3'd5);
      bus.req = 8'h00;
      step();
      chk_idle("prio.rel5", 1'b0);
      bus.req = 8'b0010_0001;
      step();
      chk_grant("prio.g0", 3'd0);
      bus.req = 8'b0010_0000;
      step();
      chk_idle("prio.rel0", 1'b0);
      step();
      chk_grant("prio.then5", 3'd5);
      bus.req = 8'h00;
      step();

      // Timeout: req[3] held, req[6] joins at grant cycle 2; ptr=6 here.
      bus.req = 8'b0000_1000;
      step();
      chk_grant("to.c1", 3'd3);
      step();
      chk_grant("to.c2", 3'd3);
      bus.req = 8'b0100_1000;
      step();
      chk_grant("to.c3", 3'd3);
      step();
      chk_grant("to.c4", 3'd3);
      step();
      chk_idle("to.revoke", 1'b1);
      step();
      chk_grant("to.g6", 3'd6);
      bus.req = 8'h00;
      step();
      chk_idle("to.rel6", 1'b0);

      // Lone requester holds past MAX_HOLD without timeout.
      bus.req = 8'b0000_1000;
      for (int k = 0; k < 8; k++) begin
         step();
         chk_grant($sformatf("lone.c%0d", k), 3'd3);
      end

      // Reset mid-grant, then first grant after reset scans from 0.
      bus.req = 8'h00;
      step();
      bus.req = 8'b0010_0000;
      step();
      chk_grant("rst.g5", 3'd5);
      rst_n = 1'b0;
      #1;
      chk_idle("rst.async", 1'b0);
      chk("rst.async.gnt_id", {5'd0, bus.gnt_id}, 8'd0);
      bus.req = 8'b1010_0000;
      step();
      chk_idle("rst.held", 1'b0);
      rst_n = 1'b1;
      step();
      chk_grant("rst.first", 3'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/encoder_rr_arbiter.md
# encoder_rr_arbiter

Round-robin arbiter that shares the 8-input encoder path between eight requesters. It grants exactly one requester at a time and presents the grant both as a one-hot vector, in the encoder's input format, and as its registered 3-bit index, in the encoder's output format. Fairness comes from a rotating priority pointer, and an optional hold timeout stops any one requester from monopolising the path. The block sits between the request sources and the encoder/consumer logic.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles while another request is pending; 0 disables the timeout.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request lines; req[i] is held high by requester i until it is done.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- gnt_id  output  3  binary index of the granted requester; equals encode(gnt) whenever gnt_valid=1.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values: gnt=8'b0, gnt_id=3'd0, gnt_valid=0, timeout=0, pointer ptr=3'd0, hold counter=0, state IDLE.
- State IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, … ptr+7, wrapping modulo 8.
  - Register gnt=1<<sel, gnt_id=sel and gnt_valid=1, clear the hold counter, and go to GRANT.
  - If req==0, remain in IDLE with outputs zero.
- State GRANT, normal release:
  - If req[gnt_id]=0, release the grant: gnt=0, gnt_valid=0, gnt_id holds its last value.
  - Update ptr=gnt_id+1 (3'd7 wraps to 3'd0) and return to IDLE.
- State GRANT, forced release:
  - Applies when MAX_HOLD≠0, the hold counter equals MAX_HOLD-1, and any other req bit is set.
  - Release exactly as in a normal release, and also pulse timeout=1 for that cycle.
- State GRANT, otherwise:
  - Keep the grant and increment the hold counter, saturating at MAX_HOLD-1.
  - If no other requester is pending, the grant holds indefinitely, even past MAX_HOLD.
- Requests from other requesters that change during GRANT do not affect the current grant.
- After a forced release the revoked requester may keep req high. It is then re-arbitrated normally with ptr already advanced past it.
- Only the registered gnt is ever one-hot; gnt is never multi-hot under any input pattern.
- Reset mid-operation: asserting rst_n=0 immediately clears all outputs and state (asynchronous). The first grant after reset uses ptr=0.

## Timing
- Grant latency: req rises at edge N (IDLE) → gnt_valid=1 after edge N+1.
- Release latency: req[gnt_id] falls before edge M → gnt_valid=0 after edge M.
- There is always at least one IDLE cycle between consecutive grants, so the back-to-back grant period is grant length plus 1.
- Timeout: the grant lasts exactly MAX_HOLD cycles. timeout is high in the cycle after the last grant cycle, coinciding with the first IDLE cycle.
- Worst-case wait for a continuously requesting client: 7×(MAX_HOLD+1) cycles, then its grant cycle.
- Outputs are registered only; there is no combinational path from req to any output.

## Test plan
- Single request:
  - Stimulus: req=8'b0000_0100 held 5 cycles, then 0.
  - Required: gnt=8'b0000_0100 and gnt_id=3'd2 one cycle after req rises, for 5 cycles; then gnt_valid=0 and ptr=3.
- Rotation:
  - Stimulus: req=8'hFF, each grantee dropping its req for the cycle after it is granted.
  - Required: gnt_id sequence 0,1,2,…,7,0, with one idle cycle between grants.
- Pointer priority:
  - Stimulus: after requester 5 releases (ptr=6), assert req=8'b0010_0001.
  - Required: grant goes to 0, not 5; the sequence then continues with 5.
- Timeout (MAX_HOLD=4):
  - Stimulus: req[3] held high; req[6] raised at cycle 2 of the grant.
  - Required: gnt_id=3 for exactly 4 cycles, timeout pulse, then gnt_id=6.
- Timeout, lone requester:
  - Stimulus: req[3] held with no other requests.
  - Required: the grant persists more than 4 cycles and timeout never pulses.
- Reset mid-grant:
  - Stimulus: drive rst_n=0 while gnt_id=5 is granted, then release reset with req=8'b1010_0000.
  - Required: outputs are zero asynchronously; the first grant after reset is gnt_id=5 (ptr=0, scan 0→5).
